immgen: RTL and testbench



---
 rtl/immgen_pkg.sv | 29 ++
 rtl/immgen_fmt_decode.sv | 52 +++++
 rtl/immgen.sv | 55 +++++
 tb/tb_immgen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// Shared types and opcode-field patterns for the RV32I immediate generator.
package immgen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam int unsigned INST_WIDTH = 32;

  // Major class, inst[6:5]
  localparam logic [1:0] CLS_LOAD   = 2'b00;
  localparam logic [1:0] CLS_STORE  = 2'b01;
  localparam logic [1:0] CLS_FP     = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  // Sub-class, inst[4:2]
  localparam logic [2:0] SUB_U      = 3'b101;
  localparam logic [2:0] SUB_OP     = 3'b100;
  localparam logic [2:0] SUB_JALR   = 3'b001;
  localparam logic [2:0] SUB_JAL    = 3'b011;
  localparam logic [2:0] SUB_SYSTEM = 3'b100;

endpackage

// File: rtl/immgen_fmt_decode.sv
// Combinational immediate-format classifier from inst[6:2].
// Optional CSR-immediate (Z) decode is enabled by IMMGEN_ZICSR_EN.
module immgen_fmt_decode
  import immgen_pkg::*;
(
  input  logic [4:0] opc,
  input  logic       csr_imm,
  output imm_fmt_e   fmt_c
);

  logic [1:0] cls;
  logic [2:0] sub;

  assign cls = opc[4:3];
  assign sub = opc[2:0];

`ifndef IMMGEN_ZICSR_EN
  logic unused_csr_imm;
  assign unused_csr_imm = csr_imm;
`endif

  always_comb begin
    fmt_c = FMT_NONE;
    case (cls)
      CLS_LOAD: begin
        fmt_c = (sub == SUB_U) ? FMT_U : FMT_I;
      end
      CLS_STORE: begin
        if (sub == SUB_U)       fmt_c = FMT_U;
        else if (sub == SUB_OP) fmt_c = FMT_NONE;
        else                    fmt_c = FMT_S;
      end
      CLS_FP: begin
        fmt_c = FMT_NONE;
      end
      CLS_BRANCH: begin
        if (sub == SUB_JALR)     fmt_c = FMT_I;
        else if (sub == SUB_JAL) fmt_c = FMT_J;
        else if (sub == SUB_SYSTEM) begin
`ifdef IMMGEN_ZICSR_EN
          fmt_c = csr_imm ? FMT_Z : FMT_NONE;
`else
          fmt_c = FMT_NONE;
`endif
        end
        else fmt_c = FMT_B;
      end
      default: fmt_c = FMT_NONE;
    endcase
  end

endmodule

// File: rtl/immgen.sv
// RV32I immediate generator: decodes format, assembles the extended immediate, registers both.
// Optional feature macro: IMMGEN_ZICSR_EN (CSR uimm as Z format).
module immgen
  import immgen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst,
  output logic [DATA_WIDTH-1:0] extended_immediate,
  output logic [2:0]            imm_fmt
);

  imm_fmt_e              fmt_c;
  logic [31:0]           imm32_c;
  logic [DATA_WIDTH-1:0] imm_c;

  logic unused_inst;
  assign unused_inst = ^inst[1:0];

  immgen_fmt_decode u_fmt_decode (
    .opc     (inst[6:2]),
    .csr_imm (inst[14]),
    .fmt_c   (fmt_c)
  );

  // Gather immediate bits into a 32-bit value; everything but Z is signed from bit 31.
  always_comb begin
    imm32_c = '0;
    imm_c   = '0;
    case (fmt_c)
      FMT_I: imm32_c = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm32_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32_c = {inst[31:12], 12'b0};
      FMT_J: imm32_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z: imm32_c = {27'b0, inst[19:15]};
      default: imm32_c = '0;
    endcase
    if (fmt_c == FMT_Z) imm_c = DATA_WIDTH'(imm32_c);
    else                imm_c = DATA_WIDTH'($signed(imm32_c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      extended_immediate <= '0;
      imm_fmt            <= FMT_NONE;
    end else begin
      extended_immediate <= imm_c;
      imm_fmt            <= fmt_c;
    end
  end

endmodule

// File: tb/tb_immgen.sv
// Self-checking bench for immgen: directed vectors, randomized stream, async reset, CSR immediates.
module tb_immgen;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [31:0]   inst;
  logic [DW-1:0] extended_immediate;
  logic [2:0]    imm_fmt;

  int total;
  int bad;

  immgen #(.DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .inst               (inst),
    .extended_immediate (extended_immediate),
    .imm_fmt            (imm_fmt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Format codes
  localparam logic [2:0] K_NONE = 3'd0, K_I = 3'd1, K_S = 3'd2, K_B = 3'd3,
                         K_U = 3'd4, K_J = 3'd5, K_Z = 3'd6;

  function automatic longint sx(input longint val, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (val >= half) ? val - (half * 2) : val;
  endfunction

  // Reference model: classify by major/minor opcode fields and build immediates arithmetically.
  function automatic void ref_model(input logic [31:0] w, output logic [2:0] f,
                                    output logic [31:0] v);
    int major, minor;
    longint val;
    major = int'(w[6:5]);
    minor = int'(w[4:2]);
    f = K_NONE;
    if (major == 0)      f = (minor == 5) ? K_U : K_I;
    else if (major == 1) f = (minor == 5) ? K_U : ((minor == 4) ? K_NONE : K_S);
    else if (major == 3) begin
      if (minor == 1)      f = K_I;
      else if (minor == 3) f = K_J;
      else if (minor == 4) begin
`ifdef IMMGEN_ZICSR_EN
        f = w[14] ? K_Z : K_NONE;
`else
        f = K_NONE;
`endif
      end
      else f = K_B;
    end
    val = 0;
    case (f)
      K_I: val = sx(longint'(w[31:20]), 12);
      K_S: val = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
      K_B: val = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                    + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
      K_U: val = longint'(w[31:12]) * 4096;
      K_J: val = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                    + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
      K_Z: val = longint'(w[19:15]);
      default: val = 0;
    endcase
    v = 32'(val);
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    inst = 32'h555FFF9F;
    #1;
    total++;
    if (extended_immediate !== '0 || imm_fmt !== K_NONE) begin
      bad++;
      $display("FAIL reset_initial: got imm=%h fmt=%0d want 0/0", extended_immediate, imm_fmt);
    end
    inst = 'x;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (extended_immediate !== '0 || imm_fmt !== K_NONE) begin
      bad++;
      $display("FAIL reset_hold: got imm=%h fmt=%0d want 0/0", extended_immediate, imm_fmt);
    end
    @(negedge clk);
    inst = 32'h0;
    rst  = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vec_inst [10];
    logic [31:0] vec_imm  [10];
    logic [2:0]  vec_fmt  [10];
    vec_inst = '{32'h555FFF9F, 32'hD55FFF9F, 32'h55FFFABF, 32'hD5FFFABF, 32'h2BFFF5FF,
                 32'hABCDE0B7, 32'hFFDFF0EF, 32'h00B50533, 32'hFFF00067, 32'h80000017};
    vec_imm  = '{32'h00000555, 32'hFFFFFD55, 32'h00000555, 32'hFFFFFD55, 32'h00000AAA,
                 32'hABCDE000, 32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFF, 32'h80000000};
    vec_fmt  = '{K_I, K_I, K_S, K_S, K_B, K_U, K_J, K_NONE, K_I, K_U};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst = vec_inst[i];
      @(posedge clk);
      #1;
      total++;
      if (extended_immediate !== vec_imm[i] || imm_fmt !== vec_fmt[i]) begin
        bad++;
        $display("FAIL directed_%0d inst=%h: got imm=%h fmt=%0d want imm=%h fmt=%0d",
                 i, vec_inst[i], extended_immediate, imm_fmt, vec_imm[i], vec_fmt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, ev;
    logic [2:0]  ef;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      w = $urandom;
      inst = w;
      ref_model(w, ef, ev);
      @(posedge clk);
      #1;
      total++;
      if (extended_immediate !== ev || imm_fmt !== ef) begin
        bad++;
        $display("FAIL random_%0d inst=%h: got imm=%h fmt=%0d want imm=%h fmt=%0d",
                 i, w, extended_immediate, imm_fmt, ev, ef);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] ev;
    logic [2:0]  ef;
    @(negedge clk);
    inst = 32'hD55FFF9F;
    @(posedge clk);
    #1;
    total++;
    if (extended_immediate !== 32'hFFFFFD55 || imm_fmt !== K_I) begin
      bad++;
      $display("FAIL async_pre: got imm=%h fmt=%0d want FFFFFD55/1", extended_immediate, imm_fmt);
    end
    // Assert reset between edges; outputs must clear before the next edge.
    inst = 32'hFFDFF0EF;
    #1 rst = 1'b1;
    #1;
    total++;
    if (extended_immediate !== '0 || imm_fmt !== K_NONE) begin
      bad++;
      $display("FAIL async_clear: got imm=%h fmt=%0d want 0/0", extended_immediate, imm_fmt);
    end
    @(posedge clk);
    #1;
    total++;
    if (extended_immediate !== '0 || imm_fmt !== K_NONE) begin
      bad++;
      $display("FAIL async_discard: got imm=%h fmt=%0d want 0/0", extended_immediate, imm_fmt);
    end
    @(negedge clk);
    rst  = 1'b0;
    inst = 32'h55FFFABF;
    ref_model(inst, ef, ev);
    @(posedge clk);
    #1;
    total++;
    if (extended_immediate !== ev || imm_fmt !== ef) begin
      bad++;
      $display("FAIL async_resume: got imm=%h fmt=%0d want imm=%h fmt=%0d",
               extended_immediate, imm_fmt, ev, ef);
    end
  endtask

  task automatic test_csr();
    logic [31:0] vec_inst [3];
    logic [31:0] ev;
    logic [2:0]  ef;
    vec_inst = '{32'h3401D073, 32'h340F9073, 32'h00000073};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inst = vec_inst[i];
      ref_model(vec_inst[i], ef, ev);
      @(posedge clk);
      #1;
      total++;
      if (extended_immediate !== ev || imm_fmt !== ef) begin
        bad++;
        $display("FAIL csr_%0d inst=%h: got imm=%h fmt=%0d want imm=%h fmt=%0d",
                 i, vec_inst[i], extended_immediate, imm_fmt, ev, ef);
      end
    end
`ifdef IMMGEN_ZICSR_EN
    ev = 32'h3;
    ef = K_Z;
`else
    ev = 32'h0;
    ef = K_NONE;
`endif
    @(negedge clk);
    inst = 32'h3401D073;
    @(posedge clk);
    #1;
    total++;
    if (extended_immediate !== ev || imm_fmt !== ef) begin
      bad++;
      $display("FAIL csrrwi: got imm=%h fmt=%0d want imm=%h fmt=%0d",
               extended_immediate, imm_fmt, ev, ef);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    inst  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_csr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
